bcd_serial_add_ctrl: RTL and testbench
======================================

# bcd_serial_add_ctrl

Sequencer that adds two DIGITS-wide packed BCD operands using one shared single-digit BCD adder stage, least-significant digit first, one digit per clock. The digit carry is registered between steps. Operands come in and results go out over valid/ready handshakes. The block sits between the operand source (keypad/register front end) and the display/result consumer, and replaces a DIGITS-wide ripple of digit adders.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  synchronous, active-low reset
- start_valid  input  1  operand bundle valid
- start_ready  output  1  block can accept operands
- a_in  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]
- b_in  input  4*DIGITS  operand B, same packing
- ci_in  input  1  carry into digit 0
- res_valid  output  1  result bundle valid
- res_ready  input  1  consumer accepts result
- sum_out  output  4*DIGITS  packed BCD sum
- co_out  output  1  carry out of most significant digit
- err_out  output  1  at least one input digit was >9

## Operation
- States: IDLE, ADD, DONE.
- IDLE: start_ready=1. When start_valid&&start_ready at a clock edge, the block:
  - captures a_in, b_in into internal registers;
  - loads the carry register with ci_in;
  - clears the digit index, sum register and err;
  - moves to ADD.
- ADD: each cycle, digit idx of A and B plus the carry register go through the digit stage.
  - Result digit is written to sum[idx]; carry register is updated; idx increments.
  - After idx=DIGITS-1: co_out takes the final carry and the state moves to DONE.
- Digit stage (combinational):
  - t = a + b + c, 5 bits.
  - If t>9: digit=(t+6)[3:0], carry=1.
  - Else: digit=t[3:0], carry=0.
  - The same rule applies for out-of-range digits; no saturation.
- err: sticky flag, set during ADD if either processed digit >9. Valid alongside res_valid.
- DONE: res_valid=1. sum_out, co_out and err_out are held stable until res_valid&&res_ready at an edge, then the state returns to IDLE.
- start_ready=0 in ADD and DONE. A start_valid held during those states is ignored, not lost; the source keeps it asserted.
- No back-to-back: a new operand is accepted no earlier than the edge after the result handshake.
- Inputs a_in, b_in, ci_in are only sampled on the accept edge and may change afterwards.

## Timing
- Reset (rst_n=0 at an edge), regardless of state:
  - state→IDLE;
  - start_ready=1 after reset;
  - res_valid=0, sum_out=0, co_out=0, err_out=0;
  - idx and carry cleared.
- Reset mid-ADD or mid-DONE discards the operation; no result is emitted.
- Accept at edge E0. ADD occupies cycles E0..E0+DIGITS-1. res_valid rises after edge E0+DIGITS. Latency is DIGITS+1 cycles from accept to first res_valid-high sample.
- res_ready may be high before res_valid; the handshake then completes on the first DONE edge, giving a minimum result valid width of 1 cycle.
- Throughput: one operation per DIGITS+2 cycles when res_ready is held high.
- sum_out and co_out are registered and change only on the final ADD edge and on reset. They are not updated digit-by-digit on the output port: an internal shadow register holds partial digits.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package bcd_pkg:
  - state enum (IDLE/ADD/DONE);
  - BCD_MAX=9, BCD_CORR=6;
  - 4-bit bcd_digit_t typedef.
- Sub-module bcd_digit_stage: purely combinational (a, b, c → digit, carry) implementing the digit rule above. Instantiated once.
- Controller contains:
  - FSM;
  - idx counter, width $clog2(DIGITS) with minimum 1;
  - operand, shadow-sum, carry and err registers;
  - digit mux (select A/B digit by idx) and demux (write sum digit by idx).

## Test plan
- DIGITS=4, A=0x1234, B=0x5678, ci=0 → after 5 cycles sum_out=0x6912, co_out=0, err_out=0.
- A=0x9999, B=0x0001, ci=0 → sum_out=0x0000, co_out=1; and A=0x0000, B=0x0000, ci=1 → sum_out=0x0001, co_out=0.
- A=0x00A5, B=0x0003 → err_out=1, sum_out=0x0108, co_out=0, following the digit rule (digit1: t=10 → 0, carry 1).
- Hold res_ready=0 for 6 cycles in DONE with start_valid=1 → res_valid and outputs stable, start_ready=0. Release → IDLE next cycle, new operand accepted on the following edge.
- Assert rst_n=0 for one edge at the second ADD cycle → next cycle all outputs 0, start_ready=1. A subsequent 0x0005+0x0005 add yields sum_out=0x0010, co_out=0.
- Random operands with a reference model: 1000 valid-digit operations with random res_ready/start_valid gaps → sum/co match decimal addition, no lost or duplicated results.

Source files
------------

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// bcd_pkg : shared types and constants for the serial BCD adder
// Revision : 1.0
// ============================================================================
package bcd_pkg;

  localparam int unsigned BCD_MAX  = 9;
  localparam int unsigned BCD_CORR = 6;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_stage.sv
`default_nettype none
// ============================================================================
// bcd_digit_stage : combinational single-digit BCD adder (a + b + c)
// Revision : 1.0
// ============================================================================
module bcd_digit_stage
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       c,
  output bcd_digit_t digit,
  output logic       carry
);

  logic [4:0] t;
  logic [4:0] t_corr;

  // Out-of-range digits go through the same correction; no saturation
  always_comb begin
    t      = 5'(a) + 5'(b) + 5'(c);
    t_corr = t + 5'(BCD_CORR);
    if (t > 5'(BCD_MAX)) begin
      digit = t_corr[3:0];
      carry = 1'b1;
    end else begin
      digit = t[3:0];
      carry = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// bcd_serial_add_ctrl : digit-serial packed BCD adder, LSD first, one digit
// per clock through a single shared digit stage, valid/ready on both sides.
// Revision : 1.0
// ============================================================================
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [4*DIGITS-1:0] a_in,
  input  logic [4*DIGITS-1:0] b_in,
  input  logic                ci_in,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [4*DIGITS-1:0] sum_out,
  output logic                co_out,
  output logic                err_out
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  bcd_digit_t [DIGITS-1:0] a_q, a_d;
  bcd_digit_t [DIGITS-1:0] b_q, b_d;
  bcd_digit_t [DIGITS-1:0] shadow_q, shadow_d;
  bcd_digit_t [DIGITS-1:0] sum_q, sum_d;
  logic                    carry_q, carry_d;
  logic                    co_q, co_d;
  logic                    err_q, err_d;

  bcd_digit_t dig_a;
  bcd_digit_t dig_b;
  bcd_digit_t dig_s;
  logic       dig_co;

  assign dig_a = a_q[idx_q];
  assign dig_b = b_q[idx_q];

  bcd_digit_stage u_stage (
    .a     (dig_a),
    .b     (dig_b),
    .c     (carry_q),
    .digit (dig_s),
    .carry (dig_co)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    shadow_d = shadow_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    co_d     = co_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d      = a_in;
          b_d      = b_in;
          carry_d  = ci_in;
          idx_d    = '0;
          shadow_d = '0;
          err_d    = 1'b0;
          state_d  = ADD;
        end
      end
      ADD: begin
        shadow_d[idx_q] = dig_s;
        carry_d         = dig_co;
        idx_d           = idx_q + IDX_W'(1);
        if ((dig_a > 4'(BCD_MAX)) || (dig_b > 4'(BCD_MAX))) begin
          err_d = 1'b1;
        end
        // Output port only sees the completed sum, never partial digits
        if (idx_q == LAST_IDX) begin
          sum_d   = shadow_d;
          co_d    = dig_co;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      co_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shadow_q <= shadow_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      co_q     <= co_d;
      err_q    <= err_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign sum_out     = sum_q;
  assign co_out      = co_q;
  assign err_out     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// tb_bcd_serial_add_ctrl : self-checking bench, decimal-arithmetic reference
// Revision : 1.0
// ============================================================================
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         ci_in;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum_out;
  logic         co_out;
  logic         err_out;

  int tests = 0;
  int fails = 0;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .ci_in       (ci_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum_out     (sum_out),
    .co_out      (co_out),
    .err_out     (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    int m = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic int pow10_digits();
    int p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Tasks start and end just after a falling edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        output logic [W-1:0] s, output logic co, output logic e);
    int n;
    int lat;
    logic stable;
    logic [W-1:0] prev_sum;
    a_in = a; b_in = b; ci_in = ci; start_valid = 1'b1;
    n = 0;
    while (!start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (start_ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_timeout start_ready=%b expected 1", start_ready);
    end
    prev_sum = sum_out;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a_in = '1; b_in = '1; ci_in = 1'b1;
    lat = 0;
    stable = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!res_valid && (sum_out !== prev_sum || start_ready !== 1'b0)) stable = 1'b0;
    end while (!res_valid && lat < DIGITS + 10);
    tests++;
    if (lat != DIGITS + 1 || res_valid !== 1'b1) begin
      fails++;
      $display("FAIL latency got=%0d res_valid=%b expected %0d", lat, res_valid, DIGITS + 1);
    end
    tests++;
    if (!stable) begin
      fails++;
      $display("FAIL busy_outputs sum_out/start_ready changed during ADD, expected sum=%h ready=0", prev_sum);
    end
    s = sum_out; co = co_out; e = err_out;
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    a_in = '0; b_in = '0; ci_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (start_ready !== 1'b1) begin fails++; $display("FAIL reset_start_ready got=%b expected 1", start_ready); end
    tests++;
    if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got=%b expected 0", res_valid); end
    tests++;
    if (sum_out !== '0) begin fails++; $display("FAIL reset_sum got=%h expected 0", sum_out); end
    tests++;
    if (co_out !== 1'b0) begin fails++; $display("FAIL reset_co got=%b expected 0", co_out); end
    tests++;
    if (err_out !== 1'b0) begin fails++; $display("FAIL reset_err got=%b expected 0", err_out); end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    logic         tc [4];
    logic [W-1:0] ts [4];
    logic         tco[4];
    logic         ter[4];
    logic [W-1:0] s;
    logic co, e;
    ta[0] = 16'h1234; tb[0] = 16'h5678; tc[0] = 0; ts[0] = 16'h6912; tco[0] = 0; ter[0] = 0;
    ta[1] = 16'h9999; tb[1] = 16'h0001; tc[1] = 0; ts[1] = 16'h0000; tco[1] = 1; ter[1] = 0;
    ta[2] = 16'h0000; tb[2] = 16'h0000; tc[2] = 1; ts[2] = 16'h0001; tco[2] = 0; ter[2] = 0;
    ta[3] = 16'h00A5; tb[3] = 16'h0003; tc[3] = 0; ts[3] = 16'h0108; tco[3] = 0; ter[3] = 1;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], tc[i], s, co, e);
      tests++;
      if (s !== ts[i] || co !== tco[i] || e !== ter[i]) begin
        fails++;
        $display("FAIL directed_%0d got sum=%h co=%b err=%b expected sum=%h co=%b err=%b",
                 i, s, co, e, ts[i], tco[i], ter[i]);
      end
      take_result();
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] s;
    logic co, e;
    logic ok;
    int n;
    run_op(16'h0042, 16'h0057, 1'b0, s, co, e);
    a_in = 16'h0500; b_in = 16'h0500; ci_in = 1'b0; start_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || sum_out !== 16'h0099 || co_out !== 1'b0 ||
          err_out !== 1'b0 || start_ready !== 1'b0) ok = 1'b0;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL hold_done got valid=%b sum=%h ready=%b expected valid=1 sum=0099 ready=0",
               res_valid, sum_out, start_ready);
    end
    take_result();
    tests++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_release got valid=%b ready=%b expected valid=0 ready=1", res_valid, start_ready);
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < DIGITS + 10);
    tests++;
    if (res_valid !== 1'b1 || n != DIGITS + 1 || sum_out !== 16'h1000 || co_out !== 1'b0) begin
      fails++;
      $display("FAIL hold_next_op got valid=%b lat=%0d sum=%h co=%b expected valid=1 lat=%0d sum=1000 co=0",
               res_valid, n, sum_out, co_out, DIGITS + 1);
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s;
    logic co, e;
    logic quiet;
    a_in = 16'h1234; b_in = 16'h5678; ci_in = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1 || sum_out !== '0 || co_out !== 1'b0 || err_out !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset got valid=%b ready=%b sum=%h co=%b err=%b expected 0 1 0000 0 0",
               res_valid, start_ready, sum_out, co_out, err_out);
    end
    quiet = 1'b1;
    for (int i = 0; i < DIGITS + 3; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) quiet = 1'b0;
    end
    tests++;
    if (!quiet) begin fails++; $display("FAIL mid_reset_ghost res_valid rose without an operation, expected 0"); end
    run_op(16'h0005, 16'h0005, 1'b0, s, co, e);
    tests++;
    if (s !== 16'h0010 || co !== 1'b0 || e !== 1'b0) begin
      fails++;
      $display("FAIL after_reset_op got sum=%h co=%b err=%b expected 0010 0 0", s, co, e);
    end
    take_result();
  endtask

  task automatic test_random();
    localparam int N = 1000;
    logic [W-1:0] q_sum[$];
    logic         q_co [$];
    int sent, got, cyc, tot, lim;
    logic acc, hs;
    sent = 0; got = 0; cyc = 0;
    lim = pow10_digits();
    start_valid = 1'b0; res_ready = 1'b0;
    while (got < N && cyc < 40000) begin
      if (!start_valid && sent < N && $urandom_range(0, 2) != 0) begin
        a_in = rand_bcd(); b_in = rand_bcd(); ci_in = 1'($urandom_range(0, 1));
        start_valid = 1'b1;
      end
      res_ready = 1'($urandom_range(0, 1));
      acc = start_valid && start_ready;
      hs  = res_valid && res_ready;
      if (hs) begin
        tests++;
        if (q_sum.size() == 0) begin
          fails++;
          $display("FAIL rand_unexpected got sum=%h with no operation outstanding", sum_out);
        end else begin
          if (sum_out !== q_sum[0] || co_out !== q_co[0] || err_out !== 1'b0) begin
            fails++;
            $display("FAIL rand_result #%0d got sum=%h co=%b err=%b expected sum=%h co=%b err=0",
                     got, sum_out, co_out, err_out, q_sum[0], q_co[0]);
          end
          void'(q_sum.pop_front());
          void'(q_co.pop_front());
        end
        got++;
      end
      if (acc) begin
        tot = bcd2int(a_in) + bcd2int(b_in) + int'(ci_in);
        q_sum.push_back(int2bcd(tot % lim));
        q_co.push_back(tot >= lim);
        sent++;
      end
      @(posedge clk);
      #1;
      if (acc) start_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    res_ready = 1'b0;
    tests++;
    if (got != N || q_sum.size() != 0) begin
      fails++;
      $display("FAIL rand_count got=%0d results outstanding=%0d expected %0d results 0 outstanding",
               got, q_sum.size(), N);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
